// File: rtl/kernel_stream_multi.sv
// kernel_stream_multi
// Streaming 3x3 convolution engine. The engine takes a raster-order pixel
// stream, builds 3x3 windows from two line buffers and applies NUM_K signed
// kernels to each window. For every interior centre pixel it emits all NUM_K
// results on a valid/ready output.
//
// Ports
//   clk, n_rst          rising-edge clock, synchronous active-low reset
//   start               begin a frame (honoured in IDLE only)
//   in_valid/in_ready   pixel input handshake, in_pixel raster order
//   coef_we/kidx/idx/data  coefficient write port (IDLE only)
//   out_valid/out_ready result handshake; out_data packs kernel k at
//                       [k*PIX_W +: PIX_W]; out_x/out_y = window centre
//   busy                high in RUN and DRAIN
//   done                one-cycle pulse at end of frame
//
// state | meaning
// IDLE  | waiting for start, coefficient writes allowed
// RUN   | accepting pixels of the current frame
// DRAIN | last pixel taken, flushing the two pipeline stages
// DONE  | single-cycle done pulse, back to IDLE
module kernel_stream_multi #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int PIX_W  = 13,
  parameter int NUM_K  = 2,
  parameter int COEF_W = 8,
  parameter int SHIFT  = 0
) (
  input  logic                                     clk,
  input  logic                                     n_rst,
  input  logic                                     start,
  input  logic                                     in_valid,
  input  logic [PIX_W-1:0]                         in_pixel,
  output logic                                     in_ready,
  input  logic                                     coef_we,
  input  logic [((NUM_K > 1) ? $clog2(NUM_K) : 1)-1:0] coef_kidx,
  input  logic [3:0]                               coef_idx,
  input  logic signed [COEF_W-1:0]                 coef_data,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [NUM_K*PIX_W-1:0]                   out_data,
  output logic [$clog2(IMG_W)-1:0]                 out_x,
  output logic [$clog2(IMG_H)-1:0]                 out_y,
  output logic                                     busy,
  output logic                                     done
);

  localparam int XW    = $clog2(IMG_W);
  localparam int YW    = $clog2(IMG_H);
  localparam int ACC_W = PIX_W + COEF_W + 5;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;

  logic [PIX_W-1:0] r_lb_top [IMG_W];
  logic [PIX_W-1:0] r_lb_mid [IMG_W];
  // Two previous columns of the window: [row][0] = column x-2, [row][1] = x-1.
  logic [PIX_W-1:0] r_win [3][2];

  logic signed [COEF_W-1:0] r_coef [NUM_K][9];

  logic                    r_s1_valid;
  logic signed [ACC_W-1:0] r_s1_sum [NUM_K];
  logic [XW-1:0]           r_s1_x;
  logic [YW-1:0]           r_s1_y;

  logic                   r_out_valid;
  logic [NUM_K*PIX_W-1:0] r_out_data;
  logic [XW-1:0]          r_out_x;
  logic [YW-1:0]          r_out_y;

  logic                    w_stall;
  logic                    w_accept;
  logic                    w_last_pix;
  logic                    w_win_ok;
  logic                    w_coef_ok;
  logic [PIX_W-1:0]        w_col [3];
  logic [PIX_W-1:0]        w_taps [9];
  logic signed [ACC_W-1:0] w_sum [NUM_K];
  logic signed [ACC_W-1:0] w_shift [NUM_K];
  logic [NUM_K*PIX_W-1:0]  w_sat_bus;

  assign w_stall    = r_out_valid & ~out_ready;
  assign w_accept   = in_valid & in_ready;
  assign w_last_pix = (r_x == X_LAST) && (r_y == Y_LAST);
  assign w_win_ok   = (r_x >= XW'(2)) && (r_y >= YW'(2));
  assign w_coef_ok  = (int'(coef_kidx) < NUM_K) && (coef_idx < 4'd9);

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_x     = r_out_x;
  assign out_y     = r_out_y;

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        busy     = 1'b1;
        in_ready = ~w_stall;
        if (in_valid && !w_stall && w_last_pix) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        // Empty once S1 is drained and the output register is free or leaving.
        if (!r_s1_valid && (!r_out_valid || out_ready)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Window for the pixel being accepted: the two stored columns plus the
  // column formed by the line buffers and the incoming pixel.
  always_comb begin
    w_col[0] = r_lb_top[r_x];
    w_col[1] = r_lb_mid[r_x];
    w_col[2] = in_pixel;
    for (int r = 0; r < 3; r++) begin
      w_taps[r*3+0] = r_win[r][0];
      w_taps[r*3+1] = r_win[r][1];
      w_taps[r*3+2] = w_col[r];
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_K; k++) begin
      w_sum[k] = '0;
      for (int t = 0; t < 9; t++) begin
        w_sum[k] = w_sum[k]
                 + ($signed({{(ACC_W-PIX_W){1'b0}}, w_taps[t]})
                  * $signed({{(ACC_W-COEF_W){r_coef[k][t][COEF_W-1]}}, r_coef[k][t]}));
      end
    end
  end

  // Clamp to [0, 2^PIX_W-1]: sign bit -> 0, any magnitude bit above PIX_W -> max.
  always_comb begin
    w_sat_bus = '0;
    for (int k = 0; k < NUM_K; k++) begin
      w_shift[k] = r_s1_sum[k] >>> SHIFT;
      if (w_shift[k][ACC_W-1])
        w_sat_bus[k*PIX_W +: PIX_W] = '0;
      else if (|w_shift[k][ACC_W-2:PIX_W])
        w_sat_bus[k*PIX_W +: PIX_W] = '1;
      else
        w_sat_bus[k*PIX_W +: PIX_W] = w_shift[k][PIX_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_x      <= '0;
      r_s1_y      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_x     <= '0;
      r_out_y     <= '0;
      for (int k = 0; k < NUM_K; k++) begin
        r_s1_sum[k] <= '0;
        for (int t = 0; t < 9; t++)
          r_coef[k][t] <= (t == 4) ? COEF_W'(1) : '0;
      end
    end else begin
      r_state <= w_state_nxt;

      if (r_state == S_IDLE) begin
        if (start) begin
          r_x <= '0;
          r_y <= '0;
        end
        if (coef_we && w_coef_ok)
          r_coef[coef_kidx][coef_idx] <= coef_data;
      end

      if (w_accept) begin
        if (r_x == X_LAST) begin
          r_x <= '0;
          r_y <= (r_y == Y_LAST) ? '0 : r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end

      if (!w_stall) begin
        r_s1_valid <= w_accept && w_win_ok;
        if (w_accept && w_win_ok) begin
          for (int k = 0; k < NUM_K; k++) r_s1_sum[k] <= w_sum[k];
          r_s1_x <= r_x - 1'b1;
          r_s1_y <= r_y - 1'b1;
        end
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_data <= w_sat_bus;
          r_out_x    <= r_s1_x;
          r_out_y    <= r_s1_y;
        end
      end
    end
  end

  // Pixel storage carries no reset; its contents are rebuilt every frame.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb_top[r_x] <= r_lb_mid[r_x];
      r_lb_mid[r_x] <= in_pixel;
      for (int r = 0; r < 3; r++) begin
        r_win[r][0] <= r_win[r][1];
        r_win[r][1] <= w_col[r];
      end
    end
  end

endmodule

// File: tb/tb_kernel_stream_multi.sv
module tb_kernel_stream_multi;

  localparam int PIX_W = 13;
  localparam int NOUT  = 3844;

  logic              clk = 1'b0;
  logic              n_rst = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [PIX_W-1:0]  in_pixel = '0;
  logic              in_ready;
  logic              coef_we = 1'b0;
  logic [0:0]        coef_kidx = '0;
  logic [3:0]        coef_idx = '0;
  logic signed [7:0] coef_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [2*PIX_W-1:0] out_data;
  logic [5:0]        out_x;
  logic [5:0]        out_y;
  logic              busy;
  logic              done;

  kernel_stream_multi dut (
    .clk(clk), .n_rst(n_rst), .start(start), .in_valid(in_valid),
    .in_pixel(in_pixel), .in_ready(in_ready), .coef_we(coef_we),
    .coef_kidx(coef_kidx), .coef_idx(coef_idx), .coef_data(coef_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_x(out_x), .out_y(out_y), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int n_out, n_done, hold_err;
  int acc130_cyc, first_ov_cyc, first_acc_cyc, last_acc_cyc, last_hs_cyc, done_cyc;
  bit timed_out;
  int got0 [4096];
  int got1 [4096];
  int gx [4096];
  int gy [4096];

  task automatic do_reset();
    @(negedge clk);
    n_rst = 1'b0; in_valid = 1'b0; start = 1'b0; coef_we = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic write_coef(input int k, input int t, input int v);
    @(negedge clk);
    coef_we = 1'b1; coef_kidx = 1'(k); coef_idx = 4'(t); coef_data = 8'(v);
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  // pattern 0: ramp pixel = x + 64*y; pattern 1: single 100 at (10,10).
  task automatic run_frame(input int pattern, input int rdy_pct, input int gap_pct,
                           input int stop_after, input bit lock_wr);
    int pi;
    bit prev_stall;
    logic [2*PIX_W-1:0] prev_data;
    logic [5:0] prev_x, prev_y;
    pi = 0; prev_stall = 0; prev_data = '0; prev_x = '0; prev_y = '0;
    n_out = 0; n_done = 0; hold_err = 0; timed_out = 0;
    acc130_cyc = -1; first_ov_cyc = -1; first_acc_cyc = -1; last_acc_cyc = -1;
    last_hs_cyc = -1; done_cyc = -1;
    @(negedge clk);
    for (int cyc = 0; ; cyc++) begin
      if (cyc > 0) @(negedge clk);
      start     = (cyc == 0);
      out_ready = ($urandom_range(99, 0) < rdy_pct);
      in_valid  = (pi < 4096) && ($urandom_range(99, 0) >= gap_pct);
      in_pixel  = (pattern == 0) ? PIX_W'(pi) : ((pi == 10*64+10) ? PIX_W'(100) : '0);
      coef_we   = lock_wr && (pi == 500);
      coef_kidx = '0; coef_idx = 4'd4; coef_data = '0;
      #1;
      if (prev_stall && (!out_valid || out_data !== prev_data || out_x !== prev_x || out_y !== prev_y))
        hold_err++;
      prev_stall = out_valid && !out_ready;
      prev_data = out_data; prev_x = out_x; prev_y = out_y;
      if (in_valid && in_ready) begin
        if (pi == 0) first_acc_cyc = cyc;
        if (pi == 130) acc130_cyc = cyc;
        last_acc_cyc = cyc;
        pi++;
      end
      if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
      if (out_valid && out_ready) begin
        if (n_out < 4096) begin
          got0[n_out] = int'(out_data[PIX_W-1:0]);
          got1[n_out] = int'(out_data[2*PIX_W-1:PIX_W]);
          gx[n_out] = int'(out_x);
          gy[n_out] = int'(out_y);
        end
        n_out++;
        last_hs_cyc = cyc;
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (stop_after > 0 && pi >= stop_after) break;
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
      if (cyc >= 30000) begin timed_out = 1; break; end
    end
    start = 1'b0; in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b exp 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %0h exp 0", out_data); end
    checks++; if (out_x !== '0 || out_y !== '0) begin errors++; $display("FAIL reset_out_xy got %0d,%0d exp 0,0", out_x, out_y); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %0b%0b exp 00", busy, done); end
  endtask

  task automatic test_identity();
    int bad, first_bad;
    do_reset();
    run_frame(0, 100, 0, 0, 0);
    checks++; if (timed_out) begin errors++; $display("FAIL ident_timeout got 1 exp 0"); end
    checks++; if (n_out != NOUT) begin errors++; $display("FAIL ident_count got %0d exp %0d", n_out, NOUT); end
    checks++; if (got0[0] != 65 || got1[0] != 65) begin errors++; $display("FAIL ident_first got %0d/%0d exp 65/65", got0[0], got1[0]); end
    checks++; if (gx[0] != 1 || gy[0] != 1) begin errors++; $display("FAIL ident_first_xy got %0d,%0d exp 1,1", gx[0], gy[0]); end
    checks++; if (got0[NOUT-1] != 4030 || gx[NOUT-1] != 62 || gy[NOUT-1] != 62) begin errors++; $display("FAIL ident_last got %0d at %0d,%0d exp 4030 at 62,62", got0[NOUT-1], gx[NOUT-1], gy[NOUT-1]); end
    checks++; if (n_done != 1) begin errors++; $display("FAIL ident_done_count got %0d exp 1", n_done); end
    checks++; if (last_acc_cyc - first_acc_cyc != 4095) begin errors++; $display("FAIL ident_throughput got %0d exp 4095", last_acc_cyc - first_acc_cyc); end
    checks++; if (first_ov_cyc - acc130_cyc != 2) begin errors++; $display("FAIL ident_latency got %0d exp 2", first_ov_cyc - acc130_cyc); end
    checks++; if (done_cyc - last_hs_cyc != 1) begin errors++; $display("FAIL ident_done_delay got %0d exp 1", done_cyc - last_hs_cyc); end
    bad = 0; first_bad = -1;
    for (int i = 0; i < NOUT; i++) begin
      int cx, cy, v;
      cx = 1 + i % 62; cy = 1 + i / 62; v = cx + 64 * cy;
      if (got0[i] != v || got1[i] != v || gx[i] != cx || gy[i] != cy) begin
        bad++; if (first_bad < 0) first_bad = i;
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL ident_all got %0d bad (first idx %0d) exp 0", bad, first_bad); end
  endtask

  task automatic test_box();
    int bad;
    do_reset();
    for (int t = 0; t < 9; t++) write_coef(1, t, 1);
    run_frame(0, 100, 0, 0, 0);
    checks++; if (n_out != NOUT) begin errors++; $display("FAIL box_count got %0d exp %0d", n_out, NOUT); end
    checks++; if (got1[0] != 585) begin errors++; $display("FAIL box_first got %0d exp 585", got1[0]); end
    checks++; if (got1[NOUT-1] != 8191) begin errors++; $display("FAIL box_sat got %0d exp 8191", got1[NOUT-1]); end
    checks++; if (got0[0] != 65) begin errors++; $display("FAIL box_k0_ident got %0d exp 65", got0[0]); end
    bad = 0;
    for (int i = 0; i < NOUT; i++) begin
      int v, b;
      v = (1 + i % 62) + 64 * (1 + i / 62);
      b = (9 * v > 8191) ? 8191 : 9 * v;
      if (got0[i] != v || got1[i] != b) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL box_all got %0d bad exp 0", bad); end
  endtask

  task automatic test_laplacian();
    int bad;
    do_reset();
    for (int t = 0; t < 9; t++) write_coef(0, t, (t == 4) ? -8 : 1);
    run_frame(1, 100, 0, 0, 0);
    checks++; if (n_out != NOUT) begin errors++; $display("FAIL lap_count got %0d exp %0d", n_out, NOUT); end
    checks++; if (got0[9*62+9] != 0) begin errors++; $display("FAIL lap_centre got %0d exp 0", got0[9*62+9]); end
    checks++; if (got0[8*62+8] != 100) begin errors++; $display("FAIL lap_neighbour got %0d exp 100", got0[8*62+8]); end
    bad = 0;
    for (int i = 0; i < NOUT; i++) begin
      int cx, cy, e0, e1;
      cx = 1 + i % 62; cy = 1 + i / 62;
      e1 = (cx == 10 && cy == 10) ? 100 : 0;
      e0 = (cx >= 9 && cx <= 11 && cy >= 9 && cy <= 11 && !(cx == 10 && cy == 10)) ? 100 : 0;
      if (got0[i] != e0 || got1[i] != e1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL lap_all got %0d bad exp 0", bad); end
  endtask

  task automatic test_backpressure();
    int bad;
    do_reset();
    run_frame(0, 30, 25, 0, 0);
    checks++; if (timed_out) begin errors++; $display("FAIL bp_timeout got 1 exp 0"); end
    checks++; if (n_out != NOUT) begin errors++; $display("FAIL bp_count got %0d exp %0d", n_out, NOUT); end
    checks++; if (hold_err != 0) begin errors++; $display("FAIL bp_hold got %0d exp 0", hold_err); end
    checks++; if (n_done != 1) begin errors++; $display("FAIL bp_done got %0d exp 1", n_done); end
    bad = 0;
    for (int i = 0; i < NOUT; i++) begin
      int cx, cy, v;
      cx = 1 + i % 62; cy = 1 + i / 62; v = cx + 64 * cy;
      if (got0[i] != v || got1[i] != v || gx[i] != cx || gy[i] != cy) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_all got %0d bad exp 0", bad); end
  endtask

  task automatic test_coef_lockout();
    int bad;
    do_reset();
    run_frame(0, 100, 0, 0, 1);
    bad = 0;
    for (int i = 0; i < NOUT; i++)
      if (got0[i] != (1 + i % 62) + 64 * (1 + i / 62)) bad++;
    checks++; if (n_out != NOUT || bad != 0) begin errors++; $display("FAIL lock_run got %0d bad, %0d outputs exp 0, %0d", bad, n_out, NOUT); end
    write_coef(0, 4, 0);
    run_frame(0, 100, 0, 0, 0);
    checks++; if (got0[100] != 0) begin errors++; $display("FAIL lock_idle_k0 got %0d exp 0", got0[100]); end
    bad = 0;
    for (int i = 0; i < NOUT; i++)
      if (got0[i] != 0 || got1[i] != (1 + i % 62) + 64 * (1 + i / 62)) bad++;
    checks++; if (n_out != NOUT || bad != 0) begin errors++; $display("FAIL lock_idle_all got %0d bad, %0d outputs exp 0, %0d", bad, n_out, NOUT); end
  endtask

  task automatic test_reset_mid();
    int bad;
    do_reset();
    write_coef(0, 4, 2);
    run_frame(0, 100, 0, 1000, 0);
    n_rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid got %0b exp 0", out_valid); end
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL rmid_idle got busy %0b in_ready %0b exp 0 0", busy, in_ready); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL rmid_out_data got %0h exp 0", out_data); end
    n_rst = 1'b1;
    run_frame(0, 100, 0, 0, 0);
    checks++; if (n_out != NOUT) begin errors++; $display("FAIL rmid_count got %0d exp %0d", n_out, NOUT); end
    bad = 0;
    for (int i = 0; i < NOUT; i++) begin
      int v;
      v = (1 + i % 62) + 64 * (1 + i / 62);
      if (got0[i] != v || got1[i] != v) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rmid_all got %0d bad exp 0", bad); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_box();
    test_laplacian();
    test_backpressure();
    test_coef_lockout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
